// File: rtl/ibuf_pkg.sv
// Shared types for the level-2 instruction buffer and its execution-stage consumer.
package ibuf_pkg;
  localparam int DEF_INSTR_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHORT = 2'd1,
    LONG  = 2'd2
  } exec_state_t;
endpackage

// File: rtl/ibuf_exec_unit_if.sv
// Issue/retire bundle between the instruction buffer (master) and the execution stage (slave).
interface ibuf_exec_unit_if import ibuf_pkg::*; #(
  parameter int INSTR_W = DEF_INSTR_W,
  parameter int CNT_W   = 16
);
  logic               issue_valid;
  logic [INSTR_W-1:0] issue_instr;
  logic               issue_is_long;
  logic               exec_busy;
  logic               exec_will_free_next;
  logic               exec_can_accept;
  logic               retire_valid;
  logic [INSTR_W-1:0] retire_instr;
  logic [CNT_W-1:0]   retire_count;
  logic               issue_overrun;

  modport master (
    output issue_valid, issue_instr, issue_is_long,
    input  exec_busy, exec_will_free_next, exec_can_accept,
    input  retire_valid, retire_instr, retire_count, issue_overrun
  );

  modport slave (
    input  issue_valid, issue_instr, issue_is_long,
    output exec_busy, exec_will_free_next, exec_can_accept,
    output retire_valid, retire_instr, retire_count, issue_overrun
  );
endinterface

// File: rtl/ibuf_exec_unit.sv
// Execution stage holding one instruction for 1 (short) or LONG_LAT (long) cycles, retire pulse one edge later.
// Backpressure: exec_can_accept comes only from registered state; issues arriving while it is low are dropped and flagged.
module ibuf_exec_unit import ibuf_pkg::*; #(
  parameter int INSTR_W  = DEF_INSTR_W,
  parameter int LONG_LAT = 4,
  parameter int CNT_W    = 16
) (
  input logic             clk,
  input logic             reset,
  ibuf_exec_unit_if.slave bus
);
  localparam int REM_W = $clog2(LONG_LAT + 1);

  generate
    if (LONG_LAT < 2 || LONG_LAT > 15) begin : g_bad_long_lat
      $error("ibuf_exec_unit: LONG_LAT must be within 2..15");
    end
  endgenerate

  exec_state_t        state_q, state_d;
  logic [REM_W-1:0]   rem_q, rem_d;
  logic [INSTR_W-1:0] cur_instr;
  logic               retire_valid_q;
  logic [INSTR_W-1:0] retire_instr_q;
  logic [CNT_W-1:0]   retire_count_q;
  logic               overrun_q;

  logic busy, will_free, can_accept, accept;

  // Kept free of any issue_* term so the buffer's pop logic sees no combinational loop.
  assign busy       = (state_q != IDLE);
  assign will_free  = busy && (rem_q == REM_W'(1));
  assign can_accept = ~busy | will_free;
  assign accept     = bus.issue_valid & can_accept;

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    if (busy) begin
      rem_d = rem_q - REM_W'(1);
      if (will_free) state_d = IDLE;
    end
    // A new accept overrides the return to IDLE, giving gap-free back-to-back occupancy.
    if (accept) begin
      if (bus.issue_is_long) begin
        state_d = LONG;
        rem_d   = REM_W'(LONG_LAT);
      end else begin
        state_d = SHORT;
        rem_d   = REM_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      rem_q          <= '0;
      cur_instr      <= '0;
      retire_valid_q <= 1'b0;
      retire_instr_q <= '0;
      retire_count_q <= '0;
      overrun_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      rem_q          <= rem_d;
      retire_valid_q <= will_free;
      if (accept) cur_instr <= bus.issue_instr;
      if (will_free) begin
        retire_instr_q <= cur_instr;
        retire_count_q <= retire_count_q + CNT_W'(1);
      end
      if (bus.issue_valid && !can_accept) overrun_q <= 1'b1;
    end
  end

  assign bus.exec_busy           = busy;
  assign bus.exec_will_free_next = will_free;
  assign bus.exec_can_accept     = can_accept;
  assign bus.retire_valid        = retire_valid_q;
  assign bus.retire_instr        = retire_instr_q;
  assign bus.retire_count        = retire_count_q;
  assign bus.issue_overrun       = overrun_q;
endmodule

// File: tb/tb_ibuf_exec_unit.sv
// Scoreboard bench for ibuf_exec_unit: expected retire words queued at issue, checked at retire.
module tb_ibuf_exec_unit;
  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  ibuf_exec_unit_if #(.INSTR_W(32), .CNT_W(16)) bus_a ();
  ibuf_exec_unit_if #(.INSTR_W(32), .CNT_W(4))  bus_b ();

  ibuf_exec_unit #(.INSTR_W(32), .LONG_LAT(4), .CNT_W(16)) u_dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a.slave)
  );

  ibuf_exec_unit #(.INSTR_W(32), .LONG_LAT(4), .CNT_W(4)) u_dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b.slave)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] sb_q[$];
  logic [15:0] cnt_exp = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic vld, input logic [31:0] instr, input logic is_long);
    bus_a.issue_valid   = vld;
    bus_a.issue_instr   = instr;
    bus_a.issue_is_long = is_long;
  endtask

  // Retire monitor: every pulse must match the oldest queued word and bump the count model.
  always @(negedge clk) begin
    if (!reset && bus_a.retire_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("retire_unexpected", 64'(bus_a.retire_instr), 64'(sb_q.size() + 1));
      end else begin
        chk("retire_instr", 64'(bus_a.retire_instr), 64'(sb_q.pop_front()));
      end
      cnt_exp = cnt_exp + 16'd1;
      chk("retire_count", 64'(bus_a.retire_count), 64'(cnt_exp));
    end
  end

  initial begin
    reset = 1'b1;
    drive_a(1'b0, 32'h0, 1'b0);
    bus_b.issue_valid   = 1'b0;
    bus_b.issue_instr   = 32'h0;
    bus_b.issue_is_long = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Idle after reset
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("idle_busy",    64'(bus_a.exec_busy), 64'd0);
      chk("idle_can_acc", 64'(bus_a.exec_can_accept), 64'd1);
      chk("idle_count",   64'(bus_a.retire_count), 64'd0);
    end
    chk("rst_will_free", 64'(bus_a.exec_will_free_next), 64'd0);
    chk("rst_retire_v",  64'(bus_a.retire_valid), 64'd0);
    chk("rst_retire_i",  64'(bus_a.retire_instr), 64'd0);
    chk("rst_overrun",   64'(bus_a.issue_overrun), 64'd0);
    next_cycle();

    // Four back-to-back shorts
    for (int i = 0; i < 4; i++) begin
      drive_a(1'b1, 32'h11 + 32'(i), 1'b0);
      sb_q.push_back(32'h11 + 32'(i));
      @(negedge clk);
      if (i > 0) chk("b2b_busy", 64'(bus_a.exec_busy), 64'd1);
      chk("b2b_can_acc", 64'(bus_a.exec_can_accept), 64'd1);
      if (i >= 2) chk("b2b_retire_v", 64'(bus_a.retire_valid), 64'd1);
      next_cycle();
    end
    drive_a(1'b0, 32'h0, 1'b0);
    @(negedge clk);
    chk("b2b_busy", 64'(bus_a.exec_busy), 64'd1);
    chk("b2b_retire_v", 64'(bus_a.retire_valid), 64'd1);
    next_cycle();
    @(negedge clk);
    chk("b2b_retire_v", 64'(bus_a.retire_valid), 64'd1);
    chk("b2b_idle", 64'(bus_a.exec_busy), 64'd0);
    next_cycle();
    @(negedge clk);
    chk("b2b_retire_end", 64'(bus_a.retire_valid), 64'd0);
    chk("b2b_count", 64'(bus_a.retire_count), 64'd4);
    next_cycle();

    // Long 0xAA with the follow-on word held valid throughout
    drive_a(1'b1, 32'hAA, 1'b1);
    sb_q.push_back(32'hAA);
    sb_q.push_back(32'hBB);
    next_cycle();
    drive_a(1'b1, 32'hBB, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("long_can_acc_lo", 64'(bus_a.exec_can_accept), 64'd0);
      chk("long_will_free_lo", 64'(bus_a.exec_will_free_next), 64'd0);
      next_cycle();
    end
    @(negedge clk);
    chk("long_can_acc_hi", 64'(bus_a.exec_can_accept), 64'd1);
    chk("long_will_free", 64'(bus_a.exec_will_free_next), 64'd1);
    chk("long_overrun", 64'(bus_a.issue_overrun), 64'd1);
    next_cycle();
    drive_a(1'b0, 32'h0, 1'b0);
    @(negedge clk);
    chk("long_no_gap", 64'(bus_a.exec_busy), 64'd1);
    chk("long_retire_v", 64'(bus_a.retire_valid), 64'd1);
    next_cycle();
    @(negedge clk);
    chk("long_bb_done", 64'(bus_a.exec_busy), 64'd0);
    next_cycle();

    // Overrun: 0xEE offered while a long is in flight must be dropped
    drive_a(1'b1, 32'hC1, 1'b1);
    sb_q.push_back(32'hC1);
    next_cycle();
    drive_a(1'b1, 32'hEE, 1'b0);
    next_cycle();
    drive_a(1'b0, 32'h0, 1'b0);
    repeat (6) next_cycle();
    @(negedge clk);
    chk("ovr_sticky", 64'(bus_a.issue_overrun), 64'd1);
    chk("ovr_idle", 64'(bus_a.exec_busy), 64'd0);
    chk("ovr_count", 64'(bus_a.retire_count), 64'd7);
    next_cycle();

    // Reset during cycle 2 of a long instruction
    drive_a(1'b1, 32'hD1, 1'b1);
    next_cycle();
    drive_a(1'b0, 32'h0, 1'b0);
    next_cycle();
    reset = 1'b1;
    cnt_exp = '0;
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_busy",    64'(bus_a.exec_busy), 64'd0);
    chk("mid_rst_can_acc", 64'(bus_a.exec_can_accept), 64'd1);
    chk("mid_rst_retire",  64'(bus_a.retire_valid), 64'd0);
    chk("mid_rst_instr",   64'(bus_a.retire_instr), 64'd0);
    chk("mid_rst_count",   64'(bus_a.retire_count), 64'd0);
    chk("mid_rst_overrun", 64'(bus_a.issue_overrun), 64'd0);
    repeat (6) next_cycle();

    // 4-bit retire counter wraps after 16 and reads 1 after 17
    for (int i = 0; i < 17; i++) begin
      bus_b.issue_valid   = 1'b1;
      bus_b.issue_instr   = 32'(i + 1);
      bus_b.issue_is_long = 1'b0;
      next_cycle();
    end
    bus_b.issue_valid = 1'b0;
    repeat (3) next_cycle();
    @(negedge clk);
    chk("wrap_count", 64'(bus_b.retire_count), 64'd1);
    chk("wrap_last_instr", 64'(bus_b.retire_instr), 64'd17);

    chk("sb_drain", 64'(sb_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/ibuf_exec_unit.md
# ibuf_exec_unit

Execution-stage model sitting directly downstream of the level-2 instruction buffer. It accepts one instruction per pop and holds it for a fixed latency: 1 cycle for short instructions, `LONG_LAT` cycles for long ones. It drives `exec_busy`, `exec_will_free_next` and `exec_can_accept` back to the buffer, and it retires completed instructions with a one-cycle pulse. It is the consumer that the buffer's pop and bypass logic are qualified against.

## Interface
- `INSTR_W`, default 32: instruction word width.
- `LONG_LAT`, default 4: busy cycles for a long instruction. Legal range is 2..15; out-of-range values fail elaboration.
- `CNT_W`, default 16: width of the retire counter.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `issue_valid`  in  1  buffer pop or bypass presents an instruction this cycle.
- `issue_instr`  in  INSTR_W  instruction word.
- `issue_is_long`  in  1  instruction uses the long latency; only meaningful with `issue_valid`.
- `exec_busy`  out  1  an instruction occupies the unit this cycle.
- `exec_will_free_next`  out  1  current busy cycle is the last one.
- `exec_can_accept`  out  1  combinational: `~exec_busy | exec_will_free_next`.
- `retire_valid`  out  1  one-cycle pulse; an instruction completed.
- `retire_instr`  out  INSTR_W  word of the completing instruction, valid with `retire_valid`.
- `retire_count`  out  CNT_W  running total of retired instructions; wraps modulo 2^CNT_W.
- `issue_overrun`  out  1  sticky: `issue_valid` was seen while `exec_can_accept` was 0.

## Operation
- States: IDLE, SHORT and LONG.
  - Remaining-cycle counter `rem` is $clog2(LONG_LAT+1) bits wide.
  - Instruction holding register `cur_instr`.
- Accept condition: `issue_valid & exec_can_accept`.
  - On accept, load `cur_instr`.
  - Set `rem` to 1 (SHORT) or `LONG_LAT` (LONG).
  - State follows `issue_is_long`.
- While busy, `rem` decrements each edge.
- `exec_will_free_next` is asserted when `rem == 1`.
- Completion is the edge where `rem == 1`. At that edge:
  - Register `retire_valid <= 1` and `retire_instr <= cur_instr`.
  - Increment `retire_count`.
  - Go to IDLE unless a new accept occurs at the same edge.
- Simultaneous completion and accept: the retiring instruction retires, the new one loads, and `exec_busy` stays high with no gap.
- `exec_busy` is high iff state != IDLE.
- `issue_valid` with `exec_can_accept == 0`:
  - The instruction is ignored and current state is unaffected.
  - `issue_overrun` sets and holds until reset.
- `issue_is_long` without `issue_valid` is ignored.
- `retire_count` wraps from all-ones to 0 without any flag.

## Timing
- Reset values:
  - State IDLE, `rem` 0.
  - `exec_busy` 0, `exec_will_free_next` 0, so `exec_can_accept` is 1.
  - `retire_valid` 0, `retire_instr` 0, `retire_count` 0, `issue_overrun` 0.
- Reset mid-operation: the in-flight instruction is dropped. It produces no retire pulse and the count is not incremented.
- Short instruction accepted at edge t:
  - Busy in cycle t..t+1.
  - `exec_will_free_next` is 1 in that same cycle.
  - `retire_valid` is high in cycle t+1..t+2.
- Long instruction accepted at edge t:
  - Busy for `LONG_LAT` cycles.
  - `exec_will_free_next` is high only in the last busy cycle.
  - `retire_valid` is high in the cycle following it.
- Throughput:
  - Back-to-back shorts sustain one accept per cycle.
  - A long instruction blocks further accepts until its last busy cycle.
- `exec_can_accept` is purely combinational from registered state, with no path from `issue_*`. This keeps it loop-free with the buffer's pop logic.
- Retire latency from accept: 1 edge for short, `LONG_LAT` edges for long.

## Structure
- Shared package `ibuf_pkg` holds:
  - `INSTR_W` default.
  - `exec_state_t` enum (IDLE, SHORT, LONG).
- Single module, no sub-modules. The latency counter is a few lines and does not merit its own block.
- Parameter legality is checked with an elaboration-time assertion.

## Test plan
- Reset, then idle: `exec_busy`=0, `exec_can_accept`=1, `retire_count`=0 held for 5 cycles.
- Four back-to-back short issues, words 0x11..0x14:
  - `exec_busy` stays 1 for 4 cycles.
  - `retire_valid` pulses on 4 consecutive cycles with 0x11..0x14 in order.
  - `retire_count`=4.
- Long issue 0xAA with `LONG_LAT`=4, and `issue_valid` held each cycle:
  - `exec_can_accept`=0 for 3 cycles.
  - The next instruction is accepted in the 4th cycle.
  - 0xAA retires in cycle 5 with no busy gap.
- Issue while `exec_can_accept`=0:
  - `issue_overrun` goes to 1 and stays 1.
  - The in-flight instruction still retires correctly.
  - The ignored word never appears on `retire_instr`.
- Reset asserted during cycle 2 of a long instruction:
  - No `retire_valid` pulse.
  - All outputs at reset values in the next cycle.
- `CNT_W`=4, 17 short retires: `retire_count` wraps and reads 1.
